// File: rtl/mdu_iter_if.sv
// Op request / result handshake between the core execute stage and the multiply/divide unit.
// The core drives the master side; the unit implements the slave side.
interface mdu_iter_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, op, src1, src2, flush, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, op, src1, src2, flush, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M mul/div: one bit per cycle, XLEN+1 cycles per op (divide-by-zero/overflow: 1 cycle).
// Accepts only when idle; the registered result is held until out_ready, and flush aborts at any point.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_iter_if.slave  bus
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            neg_q;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;

  // Operand decode at the accept edge
  logic            s1_sgn, s2_sgn, n1, n2, is_div, div0, ovf;
  logic [XLEN-1:0] abs1, abs2, spec_res;

  always_comb begin
    s1_sgn   = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    s2_sgn   = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    n1       = s1_sgn && bus.src1[XLEN-1];
    n2       = s2_sgn && bus.src2[XLEN-1];
    abs1     = n1 ? -bus.src1 : bus.src1;
    abs2     = n2 ? -bus.src2 : bus.src2;
    is_div   = bus.op[2];
    div0     = (bus.src2 == '0);
    ovf      = ((bus.op == 3'd4) || (bus.op == 3'd6))
               && (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.src2);
    spec_res = div0 ? (bus.op[1] ? bus.src1 : '1)
                    : (bus.op[1] ? '0 : bus.src1);
  end

  // One iteration: shift-add multiply and restoring divide step
  logic [XLEN:0]     mul_sum, shifted, diff;
  logic              ge;
  logic [2*XLEN-1:0] prod_nx, prod_fin;
  logic [XLEN-1:0]   rem_nx, quo_nx, quo_fin, rem_fin, res_fin;

  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_nx  = {mul_sum, prod[XLEN-1:1]};
    shifted  = {rem, quo[XLEN-1]};
    ge       = (shifted >= {1'b0, b_q});
    diff     = shifted - {1'b0, b_q};
    rem_nx   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nx   = {quo[XLEN-2:0], ge};
    prod_fin = neg_q ? -prod_nx : prod_nx;
    quo_fin  = neg_q ? -quo_nx : quo_nx;
    rem_fin  = neg_q ? -rem_nx : rem_nx;
    case (op_q)
      3'd0:                res_fin = prod_fin[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    res_fin = prod_fin[2*XLEN-1:XLEN];
      3'd4, 3'd5:          res_fin = quo_fin;
      default:             res_fin = rem_fin;
    endcase
  end

  assign bus.in_ready = (state == IDLE) && !bus.flush && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      neg_q          <= 1'b0;
      cnt            <= '0;
      prod           <= '0;
      rem            <= '0;
      quo            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
    end else if (bus.flush) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.op;
            a_q   <= abs1;
            b_q   <= abs2;
            // Remainder takes the dividend's sign; everything else the product of signs
            neg_q <= (bus.op[2] && bus.op[1]) ? n1 : (n1 ^ n2);
            prod  <= {{XLEN{1'b0}}, abs2};
            rem   <= '0;
            quo   <= abs1;
            if (is_div && (div0 || ovf)) begin
              bus.out_result <= spec_res;
              bus.out_valid  <= 1'b1;
              state          <= DONE;
            end else begin
              cnt   <= CW'(XLEN);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          prod <= prod_nx;
          rem  <= rem_nx;
          quo  <= quo_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.out_result <= res_fin;
            bus.out_valid  <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: arithmetic results, latency, result hold, flush and reset abort.
module tb_mdu_iter;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  mdu_iter_if #(.XLEN(32)) bus();

  mdu_iter #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      tick();
      w++;
    end
    check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.op       = o;
    bus.src1     = a;
    bus.src2     = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    // Scramble operands after accept; the unit must ignore them
    bus.op       = 3'($urandom);
    bus.src1     = $urandom;
    bus.src2     = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(tag, o, a, b);
    wait_out(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, bus.out_result, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, "_rel"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result",    bus.out_result,     32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Multiply family
    run("mul_7x-3",   3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);

    // Divide family
    run("div_-7_2",   3'd4, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33);
    run("rem_-7_2",   3'd6, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33);
    run("divu_100_7", 3'd5, 32'd100,      32'd7,        32'd14,       33);
    run("remu_100_7", 3'd7, 32'd100,      32'd7,        32'd2,        33);
    run("divu_max_1", 3'd5, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 33);

    // Division special cases complete one cycle after accept
    run("div_5_0",    3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run("remu_5_0",   3'd7, 32'd5,        32'd0,        32'd5,        1);
    run("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Result held while the consumer stalls
    issue("hold", 3'd5, 32'd100, 32'd7);
    wait_out(lat);
    check_eq("hold_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_res",   bus.out_result,     32'd14);
      check_eq("hold_nordy", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("hold_rel_valid", 32'(bus.out_valid), 32'd0);
    check_eq("hold_rel_ready", 32'(bus.in_ready),  32'd1);

    // Flush with the counter at 17
    issue("flush", 3'd0, 32'd9, 32'd9);
    repeat (15) tick();
    bus.flush = 1'b1;
    #1;
    check_eq("flush_nordy", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    check_eq("flush_valid", 32'(bus.out_valid), 32'd0);
    check_eq("flush_ready", 32'(bus.in_ready),  32'd1);
    quiet("flush_quiet", 40);

    // Reset pulse in the middle of a second op
    issue("rstmid", 3'd5, 32'd1000, 32'd3);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check_eq("rstmid_nordy",  32'(bus.in_ready),  32'd0);
    check_eq("rstmid_valid",  32'(bus.out_valid), 32'd0);
    check_eq("rstmid_result", bus.out_result,     32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rstmid_ready", 32'(bus.in_ready), 32'd1);
    quiet("rstmid_quiet", 40);

    run("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
